regfile_wport_arbiter: RTL



---
 rtl/rf_arb_pkg.sv | 23 ++
 rtl/rf_arb_starve.sv | 71 +++++++
 rtl/regfile_wport_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Also imported by the register file and the interrupt controller.
package rf_arb_pkg;

    // Register that holds the exception PC after a timer interrupt.
    localparam int EPC_REG_DEFAULT = 26;

    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_EPC,
        GNT_WB,
        GNT_MDU
    } gnt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FORCE
    } arb_state_e;

endpackage

// File: rtl/rf_arb_starve.sv
// MDU starvation guard: counts cycles an MDU result waits for the write port
// and raises force_mdu once the wait reaches STARVE_LIMIT.
module rf_arb_starve
    import rf_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mdu_valid,
    input  logic mdu_ready,
    output logic force_mdu
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_e              state_q, state_d;
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [STARVE_CNT_W-1:0] cnt_inc;
    logic                    waiting;

    assign waiting   = mdu_valid && !mdu_ready;
    assign force_mdu = (state_q == ST_FORCE);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        cnt_inc      = (state_q == ST_IDLE) ? STARVE_CNT_W'(1) : starve_cnt_q + STARVE_CNT_W'(1);

        unique case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (waiting) begin
                    // Going to FORCE as the count reaches the limit makes the
                    // next cycle the forced grant: LIMIT+1 cycles worst case.
                    starve_cnt_d = cnt_inc;
                    state_d      = (cnt_inc == LIMIT) ? ST_FORCE : ST_WAIT;
                end else begin
                    starve_cnt_d = '0;
                    state_d      = ST_IDLE;
                end
            end
            ST_FORCE: begin
                // Stay forced while an EPC save preempts; leave on transfer or
                // if the MDU withdraws its request.
                if (!waiting) begin
                    starve_cnt_d = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                starve_cnt_d = '0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Single register-file write port shared by WB, the MDU and the EPC save.
// Fixed priority EPC > forced MDU > WB > MDU; reserved registers are guarded.
module regfile_wport_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int EPC_REG      = EPC_REG_DEFAULT,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_waddr,
    input  logic [DATA_W-1:0] mdu_wdata,
    output logic              mdu_ready,
    input  logic              epc_req,
    input  logic [DATA_W-1:0] epc_data,
    output logic              stall,
    output logic              illegal_wr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam logic [ADDR_W-1:0] EPC_ADDR = ADDR_W'(EPC_REG);

    logic              epc_pend_q, epc_pend_d;
    logic [DATA_W-1:0] epc_buf_q, epc_buf_d;
    logic              force_mdu;
    gnt_e              gnt;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_data;
    logic              src_reserved;

    rf_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .force_mdu (force_mdu)
    );

    // Holding reset blanks every grant, so all outputs read 0 during reset.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (epc_pend_q)                  gnt = GNT_EPC;
            else if (force_mdu && mdu_valid) gnt = GNT_MDU;
            else if (wb_we)                  gnt = GNT_WB;
            else if (mdu_valid)              gnt = GNT_MDU;
        end
    end

    always_comb begin
        src_addr = (gnt == GNT_MDU) ? mdu_waddr : wb_waddr;
        src_data = (gnt == GNT_MDU) ? mdu_wdata : wb_wdata;
    end

    assign src_reserved = (src_addr == '0) || (src_addr == EPC_ADDR);

    always_comb begin
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        illegal_wr = 1'b0;
        unique case (gnt)
            GNT_EPC: begin
                rf_we    = 1'b1;
                rf_waddr = EPC_ADDR;
                rf_wdata = epc_buf_q;
            end
            GNT_WB, GNT_MDU: begin
                // A write to r0 or the EPC register is still consumed, just
                // never reaches the register file.
                if (src_reserved) begin
                    illegal_wr = 1'b1;
                end else begin
                    rf_we    = 1'b1;
                    rf_waddr = src_addr;
                    rf_wdata = src_data;
                end
            end
            default: ;
        endcase
    end

    assign mdu_ready = (gnt == GNT_MDU);
    assign stall     = wb_we && (gnt == GNT_WB ? 1'b0 : !rst);

    // A fresh pulse in the same cycle as the grant re-arms the save.
    always_comb begin
        epc_pend_d = epc_pend_q;
        epc_buf_d  = epc_buf_q;
        if (gnt == GNT_EPC) epc_pend_d = 1'b0;
        if (epc_req) begin
            epc_pend_d = 1'b1;
            epc_buf_d  = epc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            epc_pend_q <= 1'b0;
            // NOTE: the data buffer is a handful of flops, not a memory, so it
            // is cleared with the valid flag to keep reset state deterministic.
            epc_buf_q  <= '0;
        end else begin
            epc_pend_q <= epc_pend_d;
            epc_buf_q  <= epc_buf_d;
        end
    end

endmodule
